mult_ctrl: RTL and testbench

- Control FSM that sequences the 8-bit signed shift-add multiplier datapath (17-bit X:A:B shift register with 9-bit add/subtract units).
- Issues one-cycle load, clear, add, subtract and shift commands to run N add-shift iterations per multiply, then holds the product until Run is released.
- Sits between the debounced front-panel controls (Run, ClearA_LoadB) and the datapath register.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_ctrl.sv | 114 +++++++++++
 tb/tb_mult_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the signed shift-add multiplier controller.
//   state_t   : controller FSM states
//   N_DEFAULT : default operand width, which is also the number of add/shift iterations
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    WAIT,
    ARITH,
    SHIFT,
    HOLD
  } state_t;

  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl
// Control FSM for the 8-bit signed shift-add multiplier datapath, which uses a
// 17-bit X:A:B shift register and 9-bit add/subtract units.
// Each multiply runs N add/shift iterations. The product is then held until Run
// is released.
//
// Ports
//   Clk          : system clock, rising edge
//   Reset        : synchronous, active-high; returns the FSM to IDLE
//   Run          : level; high starts a multiply or keeps the product held
//   ClearA_LoadB : level; in IDLE, requests clearing X/A and loading B
//   M            : multiplier LSB from the datapath (registered, one clock late)
//   Ld           : clear X/A and load B
//   Redo         : clear X/A and keep B before a new multiply
//   Add          : A <= A + S
//   Sub          : A <= A - S (final iteration only)
//   Shift_En     : arithmetic right shift of X:A:B
//   Done         : product valid
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Ld,
  output logic Redo,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  // State and iteration counter.
  // The counter only advances in SHIFT, and only while the final iteration has
  // not been reached, so it stops at N-1. PREP reloads it to 0.
  // Because Run is only examined in IDLE and HOLD, a running multiply can only
  // be aborted by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) state <= PREP;
        end
        PREP: begin
          cnt   <= '0;
          state <= WAIT;
        end
        // One idle cycle so that M reflects the post-shift multiplier bit.
        WAIT: begin
          state <= ARITH;
        end
        ARITH: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state <= HOLD;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= WAIT;
          end
        end
        HOLD: begin
          if (!Run) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Command decode. At most one command is active per state, so the pulses are
  // mutually exclusive by construction.
  // The last multiplier bit is the sign bit, so its partial product is
  // subtracted rather than added.
  always_comb begin
    Ld       = 1'b0;
    Redo     = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE:  Ld = ClearA_LoadB & ~Run;
      PREP:  Redo = 1'b1;
      ARITH: begin
        if (M) begin
          if (cnt == LAST) Sub = 1'b1;
          else             Add = 1'b1;
        end
      end
      SHIFT: Shift_En = 1'b1;
      HOLD:  Done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl
// Directed testbench for mult_ctrl.
// It includes a small model of the X:A:B datapath, so complete multiplies can
// be run in a closed loop. M comes either from that model (the registered
// B[0]) or from a value forced by the bench.
// Each command cycle is compared as a vector: {Ld, Redo, Add, Sub, Shift_En, Done}.
module tb_mult_ctrl;

  localparam logic [5:0] CMD_NONE  = 6'b000000;
  localparam logic [5:0] CMD_LD    = 6'b100000;
  localparam logic [5:0] CMD_REDO  = 6'b010000;
  localparam logic [5:0] CMD_ADD   = 6'b001000;
  localparam logic [5:0] CMD_SUB   = 6'b000100;
  localparam logic [5:0] CMD_SHIFT = 6'b000010;
  localparam logic [5:0] CMD_DONE  = 6'b000001;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Ld, Redo, Add, Sub, Shift_En, Done;
  logic [5:0] cmd;

  int compared   = 0;
  int mismatched = 0;

  logic       m_sel;
  logic       m_force;
  logic [7:0] sw;
  logic       x_reg;
  logic [7:0] a_reg, b_reg;
  logic       m_reg;
  logic [8:0] sum_add, sum_sub;

  always #5 Clk = ~Clk;

  mult_ctrl #(.N(8)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Run(Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M(M),
    .Ld(Ld),
    .Redo(Redo),
    .Add(Add),
    .Sub(Sub),
    .Shift_En(Shift_En),
    .Done(Done)
  );

  assign cmd = {Ld, Redo, Add, Sub, Shift_En, Done};
  assign M   = m_sel ? m_force : m_reg;

  // Datapath model.
  // The 9-bit adders sign-extend both A and S. X captures the ninth bit of the
  // result and is shifted into A[7].
  assign sum_add = {a_reg[7], a_reg} + {sw[7], sw};
  assign sum_sub = {a_reg[7], a_reg} - {sw[7], sw};

  always_ff @(posedge Clk) begin
    m_reg <= b_reg[0];
    if (Reset) begin
      x_reg <= 1'b0;
      a_reg <= 8'h00;
      b_reg <= 8'h00;
    end else if (Ld) begin
      x_reg <= 1'b0;
      a_reg <= 8'h00;
      b_reg <= sw;
    end else if (Redo) begin
      x_reg <= 1'b0;
      a_reg <= 8'h00;
    end else if (Add) begin
      {x_reg, a_reg} <= sum_add;
    end else if (Sub) begin
      {x_reg, a_reg} <= sum_sub;
    end else if (Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    m_sel = 1'b1;
    m_force = 1'b0;
    sw = 8'h00;
    tick();
    tick();
    compared++;
    if (cmd !== CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL reset_held: got %b expected %b", cmd, CMD_NONE);
    end
    Reset = 1'b0;
    tick();
    compared++;
    if (cmd !== CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got %b expected %b", cmd, CMD_NONE);
    end
    ClearA_LoadB = 1'b1;
    #1;
    compared++;
    if (cmd !== CMD_LD) begin
      mismatched++;
      $display("[TB] FAIL reset_idle_ld: got %b expected %b", cmd, CMD_LD);
    end
    ClearA_LoadB = 1'b0;
    #1;
  endtask

  task automatic test_m_zero();
    int shifts = 0;
    logic [5:0] exp_cmd;
    m_sel = 1'b1;
    m_force = 1'b0;
    Run = 1'b1;
    tick();
    compared++;
    if (cmd !== CMD_REDO) begin
      mismatched++;
      $display("[TB] FAIL m0_redo: got %b expected %b", cmd, CMD_REDO);
    end
    for (int c = 1; c <= 24; c++) begin
      tick();
      exp_cmd = (((c - 1) % 3) == 2) ? CMD_SHIFT : CMD_NONE;
      if (Shift_En) shifts++;
      compared++;
      if (cmd !== exp_cmd) begin
        mismatched++;
        $display("[TB] FAIL m0_cycle%0d: got %b expected %b", c, cmd, exp_cmd);
      end
    end
    tick();
    compared++;
    if (cmd !== CMD_DONE) begin
      mismatched++;
      $display("[TB] FAIL m0_done_at_25: got %b expected %b", cmd, CMD_DONE);
    end
    compared++;
    if (shifts != 8) begin
      mismatched++;
      $display("[TB] FAIL m0_shift_count: got %0d expected 8", shifts);
    end
    Run = 1'b0;
    tick();
    compared++;
    if (cmd !== CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL m0_release: got %b expected %b", cmd, CMD_NONE);
    end
  endtask

  // Leaves the FSM in HOLD with Run high, which is where test_hold picks up.
  task automatic test_m_one();
    int adds = 0;
    int subs = 0;
    logic [5:0] exp_cmd;
    m_sel = 1'b1;
    m_force = 1'b1;
    Run = 1'b1;
    tick();
    compared++;
    if (cmd !== CMD_REDO) begin
      mismatched++;
      $display("[TB] FAIL m1_redo: got %b expected %b", cmd, CMD_REDO);
    end
    for (int c = 1; c <= 24; c++) begin
      tick();
      case ((c - 1) % 3)
        1:       exp_cmd = (((c - 1) / 3) < 7) ? CMD_ADD : CMD_SUB;
        2:       exp_cmd = CMD_SHIFT;
        default: exp_cmd = CMD_NONE;
      endcase
      if (Add) adds++;
      if (Sub) subs++;
      compared++;
      if (cmd !== exp_cmd) begin
        mismatched++;
        $display("[TB] FAIL m1_cycle%0d: got %b expected %b", c, cmd, exp_cmd);
      end
    end
    compared++;
    if (adds != 7 || subs != 1) begin
      mismatched++;
      $display("[TB] FAIL m1_add_sub_count: got add=%0d sub=%0d expected add=7 sub=1", adds, subs);
    end
    tick();
    compared++;
    if (cmd !== CMD_DONE) begin
      mismatched++;
      $display("[TB] FAIL m1_done: got %b expected %b", cmd, CMD_DONE);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) ClearA_LoadB = 1'b1;
      tick();
      compared++;
      if (cmd !== CMD_DONE) begin
        mismatched++;
        $display("[TB] FAIL hold_cycle%0d: got %b expected %b", i, cmd, CMD_DONE);
      end
    end
    ClearA_LoadB = 1'b0;
    Run = 1'b0;
    tick();
    compared++;
    if (cmd !== CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL hold_release: got %b expected %b", cmd, CMD_NONE);
    end
    ClearA_LoadB = 1'b1;
    #1;
    compared++;
    if (cmd !== CMD_LD) begin
      mismatched++;
      $display("[TB] FAIL hold_back_in_idle: got %b expected %b", cmd, CMD_LD);
    end
    ClearA_LoadB = 1'b0;
    Run = 1'b1;
    tick();
    compared++;
    if (cmd !== CMD_REDO) begin
      mismatched++;
      $display("[TB] FAIL hold_rerun_redo: got %b expected %b", cmd, CMD_REDO);
    end
    do_reset();
  endtask

  task automatic test_ld();
    m_sel = 1'b1;
    m_force = 1'b0;
    ClearA_LoadB = 1'b1;
    Run = 1'b0;
    #1;
    compared++;
    if (cmd !== CMD_LD) begin
      mismatched++;
      $display("[TB] FAIL ld_idle: got %b expected %b", cmd, CMD_LD);
    end
    Run = 1'b1;
    #1;
    compared++;
    if (cmd !== CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL ld_run_wins: got %b expected %b", cmd, CMD_NONE);
    end
    tick();
    compared++;
    if (cmd !== CMD_REDO) begin
      mismatched++;
      $display("[TB] FAIL ld_enter_prep: got %b expected %b", cmd, CMD_REDO);
    end
    ClearA_LoadB = 1'b0;
    tick();
    tick();
    tick();
    ClearA_LoadB = 1'b1;
    #1;
    compared++;
    if (cmd !== CMD_SHIFT) begin
      mismatched++;
      $display("[TB] FAIL ld_in_shift: got %b expected %b", cmd, CMD_SHIFT);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int shifts = 0;
    m_sel = 1'b1;
    m_force = 1'b1;
    Run = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) tick();
    compared++;
    if (cmd !== CMD_ADD) begin
      mismatched++;
      $display("[TB] FAIL mid_arith_cnt3: got %b expected %b", cmd, CMD_ADD);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    compared++;
    if (cmd !== CMD_NONE) begin
      mismatched++;
      $display("[TB] FAIL mid_after_reset: got %b expected %b", cmd, CMD_NONE);
    end
    tick();
    compared++;
    if (cmd !== CMD_REDO) begin
      mismatched++;
      $display("[TB] FAIL mid_restart_redo: got %b expected %b", cmd, CMD_REDO);
    end
    while (!Done && n < 40) begin
      tick();
      n++;
      if (Shift_En) shifts++;
    end
    compared++;
    if (n != 25 || shifts != 8) begin
      mismatched++;
      $display("[TB] FAIL mid_full_run: got edges=%0d shifts=%0d expected edges=25 shifts=8", n, shifts);
    end
    Run = 1'b0;
    tick();
  endtask

  task automatic test_closed_loop();
    logic        do_load [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  b_val   [4] = '{8'h07, 8'h80, 8'hFF, 8'h00};
    logic [7:0]  s_val   [4] = '{8'hFD, 8'h80, 8'hFF, 8'h02};
    logic [15:0] prod    [4] = '{16'hFFEB, 16'h4000, 16'h0001, 16'h0002};
    int n;
    m_sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (do_load[k]) begin
        sw = b_val[k];
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
      end
      sw = s_val[k];
      Run = 1'b1;
      n = 0;
      while (!Done && n < 60) begin
        tick();
        n++;
      end
      compared++;
      if (!Done) begin
        mismatched++;
        $display("[TB] FAIL loop%0d_timeout: got Done=0 after %0d cycles expected Done=1", k, n);
      end else if ({a_reg, b_reg} !== prod[k]) begin
        mismatched++;
        $display("[TB] FAIL loop%0d_product: got %h expected %h", k, {a_reg, b_reg}, prod[k]);
      end
      Run = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_m_zero();
    test_m_one();
    test_hold();
    test_ld();
    test_reset_mid();
    test_closed_loop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
